// File: rtl/m_imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian words from a byte
// stream, writes them sequentially, and releases the core once HALT is written.
module m_imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] HALT_WORD = 32'h00050f13
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_start,
  input  logic              w_in_valid,
  input  logic [7:0]        w_in_data,
  output logic              w_in_ready,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_waddr,
  output logic [31:0]       w_wdata,
  output logic              w_run,
  output logic              w_err,
  output logic [ADDR_W:0]   w_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MAX_WORDS - 1);

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word;

  // The incoming byte always completes the word in the top lane.
  assign word = {w_in_data, asm_q};

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wptr_d     = wptr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    count_d    = we_q ? count_q + 1'b1 : count_q;

    // A restart overrides any byte accepted on the same edge.
    if (w_start) begin
      state_d    = S_LOAD;
      byte_idx_d = 2'd0;
      wptr_d     = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (w_in_valid) begin
            if (byte_idx_q == 2'd3) begin
              we_d       = 1'b1;
              waddr_d    = wptr_q;
              wdata_d    = word;
              byte_idx_d = 2'd0;
              if (word == HALT_WORD) begin
                state_d = S_FLUSH;
              end else if (wptr_q == LAST_PTR) begin
                state_d = S_ERR;
              end else begin
                wptr_d = wptr_q + 1'b1;
              end
            end else begin
              asm_d[{byte_idx_q, 3'b000} +: 8] = w_in_data;
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        S_FLUSH: state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      wptr_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wptr_q     <= wptr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
    end
  end

  assign w_in_ready = (state_q == S_LOAD);
  assign w_run      = (state_q == S_RUN);
  assign w_err      = (state_q == S_ERR);
  assign w_we       = we_q;
  assign w_waddr    = waddr_q;
  assign w_wdata    = wdata_q;
  assign w_count    = count_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Scoreboard bench for m_imem_loader: instance A uses default capacity,
// instance B has MAX_WORDS=4 for the overflow scenario.
module tb_m_imem_loader;
  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, valid, sel;
  logic [7:0] data;
  logic start_a, start_b, valid_a, valid_b, rdy;

  logic          rdy_a, we_a, run_a, err_a;
  logic [AW-1:0] waddr_a;
  logic [31:0]   wdata_a;
  logic [AW:0]   count_a;
  logic          rdy_b, we_b, run_b, err_b;
  logic [AW-1:0] waddr_b;
  logic [31:0]   wdata_b;
  logic [AW:0]   count_b;

  int checks = 0;
  int failures = 0;
  wr_t q_a[$];
  wr_t q_b[$];
  logic prev_we_a = 1'b0;
  logic prev_we_b = 1'b0;
  logic [31:0] prog[6] = '{32'h00500093, 32'h00108133, 32'h00108093,
                           32'hfe209ee3, 32'h00908513, 32'h00050f13};

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;
  assign rdy     = sel ? rdy_b : rdy_a;

  m_imem_loader #(.ADDR_W(AW)) dut_a (
    .w_clk(clk), .w_rst_n(rst_n), .w_start(start_a), .w_in_valid(valid_a),
    .w_in_data(data), .w_in_ready(rdy_a), .w_we(we_a), .w_waddr(waddr_a),
    .w_wdata(wdata_a), .w_run(run_a), .w_err(err_a), .w_count(count_a)
  );

  m_imem_loader #(.ADDR_W(AW), .MAX_WORDS(4)) dut_b (
    .w_clk(clk), .w_rst_n(rst_n), .w_start(start_b), .w_in_valid(valid_b),
    .w_in_data(data), .w_in_ready(rdy_b), .w_we(we_b), .w_waddr(waddr_b),
    .w_wdata(wdata_b), .w_run(run_b), .w_err(err_b), .w_count(count_b)
  );

  always @(negedge clk) begin : mon_a
    wr_t e;
    if (we_a) begin
      checks++;
      if (prev_we_a) begin
        failures++;
        $display("FAIL we_a_consecutive got=1 required=0");
      end
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL wr_a_unexpected got addr=%0d data=%h required=no write", waddr_a, wdata_a);
      end else begin
        e = q_a.pop_front();
        if (waddr_a !== e.addr || wdata_a !== e.data) begin
          failures++;
          $display("FAIL wr_a got addr=%0d data=%h required addr=%0d data=%h",
                   waddr_a, wdata_a, e.addr, e.data);
        end
      end
    end
    prev_we_a = we_a;
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    if (we_b) begin
      checks++;
      if (prev_we_b) begin
        failures++;
        $display("FAIL we_b_consecutive got=1 required=0");
      end
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL wr_b_unexpected got addr=%0d data=%h required=no write", waddr_b, wdata_b);
      end else begin
        e = q_b.pop_front();
        if (waddr_b !== e.addr || wdata_b !== e.data) begin
          failures++;
          $display("FAIL wr_b got addr=%0d data=%h required addr=%0d data=%h",
                   waddr_b, wdata_b, e.addr, e.data);
        end
      end
    end
    prev_we_b = we_b;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int n;
    valid = 1'b0;
    repeat (gap) @(negedge clk);
    valid = 1'b1;
    data  = b;
    acc   = 1'b0;
    n     = 0;
    while (!acc && n < 20) begin
      acc = rdy;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL byte_accept got=not accepted required=accepted within 20 cycles");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr, input int maxgap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    if (sel) q_b.push_back(e);
    else q_a.push_back(e);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap)));
  endtask

  task automatic test_reset;
    sel = 1'b0; start = 1'b0; valid = 1'b0; data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy_a, we_a, waddr_a, wdata_a, run_a, err_a, count_a} !== '0) begin
      failures++;
      $display("FAIL reset_a got rdy=%b we=%b addr=%0d data=%h run=%b err=%b cnt=%0d required=all 0",
               rdy_a, we_a, waddr_a, wdata_a, run_a, err_a, count_a);
    end
    checks++;
    if ({rdy_b, we_b, waddr_b, wdata_b, run_b, err_b, count_b} !== '0) begin
      failures++;
      $display("FAIL reset_b got nonzero outputs required=all 0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_load;
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(prog[i], AW'(i), 0);
    checks++;
    if (we_a !== 1'b1 || rdy_a !== 1'b0 || run_a !== 1'b0) begin
      failures++;
      $display("FAIL halt_cycle got we=%b rdy=%b run=%b required we=1 rdy=0 run=0", we_a, rdy_a, run_a);
    end
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (run_a !== 1'b1 || count_a !== 11'd6 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL full_load_end got run=%b cnt=%0d err=%b required run=1 cnt=6 err=0", run_a, count_a, err_a);
    end
    checks++;
    if (q_a.size() != 0) begin
      failures++;
      $display("FAIL full_load_pending got=%0d required=0", q_a.size());
    end
  endtask

  task automatic test_gaps;
    pulse_start();
    checks++;
    if (run_a !== 1'b0 || count_a !== 11'd0) begin
      failures++;
      $display("FAIL gaps_restart got run=%b cnt=%0d required run=0 cnt=0", run_a, count_a);
    end
    for (int i = 0; i < 6; i++) send_word(prog[i], AW'(i), 3);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (run_a !== 1'b1 || count_a !== 11'd6 || q_a.size() != 0) begin
      failures++;
      $display("FAIL gaps_end got run=%b cnt=%0d pending=%0d required run=1 cnt=6 pending=0",
               run_a, count_a, q_a.size());
    end
  endtask

  task automatic test_reset_mid;
    pulse_start();
    send_byte(prog[0][7:0], 0);
    send_byte(prog[0][15:8], 0);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_a, we_a, waddr_a, wdata_a, run_a, err_a, count_a} !== '0) begin
      failures++;
      $display("FAIL reset_mid got addr=%0d data=%h rdy=%b cnt=%0d required=all 0",
               waddr_a, wdata_a, rdy_a, count_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_word(32'h00050f13, '0, 0);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (run_a !== 1'b1 || count_a !== 11'd1 || q_a.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_reload got run=%b cnt=%0d required run=1 cnt=1", run_a, count_a);
    end
  endtask

  task automatic test_restart_run;
    @(negedge clk);
    start = 1'b1;
    checks++;
    if (run_a !== 1'b1) begin
      failures++;
      $display("FAIL restart_pre got run=%b required=1", run_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (run_a !== 1'b0 || rdy_a !== 1'b1) begin
      failures++;
      $display("FAIL restart_drop got run=%b rdy=%b required run=0 rdy=1", run_a, rdy_a);
    end
    @(negedge clk);
    start = 1'b0;
    send_word(32'h00050f13, '0, 0);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (run_a !== 1'b1 || count_a !== 11'd1 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL restart_end got run=%b cnt=%0d err=%b required run=1 cnt=1 err=0", run_a, count_a, err_a);
    end
  endtask

  task automatic test_start_collision;
    logic [31:0] w;
    w = 32'h12345678;
    pulse_start();
    for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], 0);
    valid = 1'b1;
    data  = w[31:24];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (count_a !== 11'd0 || rdy_a !== 1'b1) begin
      failures++;
      $display("FAIL collision got cnt=%0d rdy=%b required cnt=0 rdy=1", count_a, rdy_a);
    end
    send_word(32'h00050f13, '0, 0);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (run_a !== 1'b1 || count_a !== 11'd1 || q_a.size() != 0) begin
      failures++;
      $display("FAIL collision_reload got run=%b cnt=%0d required run=1 cnt=1", run_a, count_a);
    end
  endtask

  task automatic test_overflow;
    sel = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'h11111111 * (i + 1), AW'(i), 0);
    checks++;
    if (err_b !== 1'b1 || rdy_b !== 1'b0 || we_b !== 1'b1) begin
      failures++;
      $display("FAIL overflow_edge got err=%b rdy=%b we=%b required err=1 rdy=0 we=1", err_b, rdy_b, we_b);
    end
    valid = 1'b1;
    data  = 8'h55;
    repeat (10) @(negedge clk);
    valid = 1'b0;
    checks++;
    if (count_b !== 11'd4 || err_b !== 1'b1 || run_b !== 1'b0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL overflow_end got cnt=%0d err=%b run=%b pending=%0d required cnt=4 err=1 run=0 pending=0",
               count_b, err_b, run_b, q_b.size());
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gaps();
    test_reset_mid();
    test_restart_run();
    test_start_collision();
    test_overflow();
    repeat (2) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL final_pending got a=%0d b=%0d required a=0 b=0", q_a.size(), q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
